// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : regfile_pkg                                                 |
// | Brief  : Shared widths and constants for the register file slice.    |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package regfile_pkg;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NREGS    = 32;
  localparam int unsigned PEND_W   = 2;
  localparam int unsigned ZERO_REG = 0;
  localparam int unsigned PEND_MAX = 3;
endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : reg_scoreboard                                              |
// | Brief  : Per-register pending-write counters with sticky error flag. |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module reg_scoreboard
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_en_i,
  input  logic [ADDR_W-1:0] inc_sel_i,
  input  logic              dec_en_i,
  input  logic [ADDR_W-1:0] dec_sel_i,
  output logic [NREGS-1:0]  pend_ge2_o,
  output logic [NREGS-1:0]  pend_eq1_o,
  output logic              pend_err_o
);

  logic [NREGS-1:0] err_vec;
  logic             pend_err_d;
  logic             pend_err_q;

  for (genvar r = 0; r < NREGS; r++) begin : g_pend
    if (r == ZERO_REG) begin : g_zero
      assign pend_ge2_o[r] = 1'b0;
      assign pend_eq1_o[r] = 1'b0;
      assign err_vec[r]    = 1'b0;
    end else begin : g_cnt
      logic [PEND_W-1:0] pend_d;
      logic [PEND_W-1:0] pend_q;
      logic              inc;
      logic              dec;
      logic              err;

      assign inc = inc_en_i & (inc_sel_i == ADDR_W'(r));
      assign dec = dec_en_i & (dec_sel_i == ADDR_W'(r));

      // Saturate instead of wrapping so a bookkeeping bug never fakes a clear.
      always_comb begin
        pend_d = pend_q;
        err    = 1'b0;
        if (inc && !dec) begin
          if (pend_q == PEND_W'(PEND_MAX)) err = 1'b1;
          else                             pend_d = pend_q + PEND_W'(1);
        end else if (dec && !inc) begin
          if (pend_q == '0) err = 1'b1;
          else              pend_d = pend_q - PEND_W'(1);
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) pend_q <= '0;
        else      pend_q <= pend_d;
      end

      assign pend_ge2_o[r] = (pend_q >= PEND_W'(2));
      assign pend_eq1_o[r] = (pend_q == PEND_W'(1));
      assign err_vec[r]    = err;
    end
  end

  assign pend_err_d = pend_err_q | (|err_vec);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend_err_q <= 1'b0;
    else      pend_err_q <= pend_err_d;
  end

  assign pend_err_o = pend_err_q;

endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : regfile_scoreboard                                          |
// | Brief  : 32x32 register file with writeback bypass and RAW stall.    |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              S3_WriteEnable,
  input  logic [ADDR_W-1:0] S3_WriteSelect,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic [ADDR_W-1:0] S1_ReadSelect1,
  input  logic [ADDR_W-1:0] S1_ReadSelect2,
  input  logic              S1_Use1,
  input  logic              S1_Use2,
  input  logic              S1_Issue,
  input  logic              S1_IssueWE,
  input  logic [ADDR_W-1:0] S1_WriteSelect,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              Stall,
  output logic              PendErr
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  pend_ge2;
  logic [NREGS-1:0]  pend_eq1;
  logic              wr_ok;
  logic              issue_ok;
  logic              byp1;
  logic              byp2;
  logic              haz1;
  logic              haz2;

  assign wr_ok = S3_WriteEnable & (S3_WriteSelect != ADDR_W'(ZERO_REG));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[S3_WriteSelect] <= ALUOut;
    end
  end

  assign byp1 = S3_WriteEnable & (S3_WriteSelect == S1_ReadSelect1);
  assign byp2 = S3_WriteEnable & (S3_WriteSelect == S1_ReadSelect2);

  always_comb begin
    ReadData1 = regs_q[S1_ReadSelect1];
    ReadData2 = regs_q[S1_ReadSelect2];
    if (byp1) ReadData1 = ALUOut;
    if (byp2) ReadData2 = ALUOut;
    if (S1_ReadSelect1 == ADDR_W'(ZERO_REG)) ReadData1 = '0;
    if (S1_ReadSelect2 == ADDR_W'(ZERO_REG)) ReadData2 = '0;
  end

  // A single outstanding write is satisfied by the bypass in the cycle it lands.
  assign haz1 = S1_Use1 & (S1_ReadSelect1 != ADDR_W'(ZERO_REG)) &
                (pend_ge2[S1_ReadSelect1] | (pend_eq1[S1_ReadSelect1] & ~byp1));
  assign haz2 = S1_Use2 & (S1_ReadSelect2 != ADDR_W'(ZERO_REG)) &
                (pend_ge2[S1_ReadSelect2] | (pend_eq1[S1_ReadSelect2] & ~byp2));

  assign Stall    = haz1 | haz2;
  assign issue_ok = S1_Issue & S1_IssueWE & ~Stall;

  reg_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .inc_en_i   (issue_ok),
    .inc_sel_i  (S1_WriteSelect),
    .dec_en_i   (S3_WriteEnable),
    .dec_sel_i  (S3_WriteSelect),
    .pend_ge2_o (pend_ge2),
    .pend_eq1_o (pend_eq1),
    .pend_err_o (PendErr)
  );

endmodule
`default_nettype wire
